hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// hazard_if: bundles the hazard-unit signals exchanged with the pipeline.
//   master : pipeline side.
//            Drives register ids, write enables, load/branch and memory-access status.
//            Receives the forwarding selects, stall/flush controls, mem_req, err and stall_cnt.
//   slave  : hazard_ctrl side, with the opposite directions.
interface hazard_if #(
   parameter int CNT_WIDTH = 16
);
   logic [4:0]           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic                 RegWriteM, RegWriteW;
   logic [1:0]           ResultSrcE;
   logic                 PCSrcE;
   logic                 MemWriteM, MemReadM, mem_ready;
   logic [1:0]           ForwardAE, ForwardBE;
   logic                 StallF, StallD, StallE, StallM;
   logic                 FlushD, FlushE;
   logic                 mem_req, err;
   logic [CNT_WIDTH-1:0] stall_cnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MemWriteM, MemReadM, mem_ready,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, mem_req, err, stall_cnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MemWriteM, MemReadM, mem_ready,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, mem_req, err, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage core with a variable-latency data memory.
//   clk : rising-edge clock.
//   rst : asynchronous active-high reset.
//   hz  : hazard_if.slave.
//         Inputs: stage register ids, write enables, load/branch flags and M-stage memory access.
//         Outputs:
//           ForwardAE/BE : ALU operand forwarding selects.
//           Stall*/Flush*: pipeline register hold and bubble controls.
//           mem_req      : data-memory request.
//           err          : sticky memory-timeout flag.
//           stall_cnt    : saturating count of StallF cycles.
module hazard_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input logic     clk,
   input logic     rst,
   hazard_if.slave hz
);

   localparam int WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

   state_t               r_state;
   logic [WCW-1:0]       r_wait_cnt;
   logic                 r_err;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   logic w_mem_acc;
   logic w_lw_stall;
   logic w_mem_hold;
   logic w_stall_f;

   // M-stage result has priority over W-stage result; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       reg_wr_m,
                                          input logic [4:0] rd_m,
                                          input logic       reg_wr_w,
                                          input logic [4:0] rd_w);
      if (reg_wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return 2'b10;
      else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

   assign w_mem_acc  = hz.MemWriteM | hz.MemReadM;
   assign w_lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   // Hold is raised combinationally in the first unready M cycle so the
   // pipeline freezes before the FSM has even left RUN.
   assign w_mem_hold = ((r_state == ST_RUN) && w_mem_acc && !hz.mem_ready) ||
                       (r_state == ST_WAIT) || (r_state == ST_ERR);

   // A memory hold freezes the whole pipe and suppresses any bubble insertion.
   assign w_stall_f = w_mem_hold | w_lw_stall;
   assign hz.StallF = w_stall_f;
   assign hz.StallD = w_stall_f;
   assign hz.StallE = w_mem_hold;
   assign hz.StallM = w_mem_hold;
   assign hz.FlushD = !w_mem_hold && hz.PCSrcE;
   assign hz.FlushE = !w_mem_hold && (w_lw_stall || hz.PCSrcE);

   assign hz.mem_req   = w_mem_acc && (r_state != ST_ERR);
   assign hz.err       = r_err;
   assign hz.stall_cnt = r_stall_cnt;

   // Memory-wait FSM. A ready in the timeout cycle wins over the error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_acc && !hz.mem_ready) begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (hz.mem_ready) begin
                  r_state <= ST_RUN;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_ERR: begin
               r_err <= 1'b1;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // Saturating performance counter of fetch-stall cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall_f && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
